// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational instruction ROM between the
// core fetch port and a debug/loader read port, with registered responses.
module rom_arbiter #(
  parameter int unsigned POS      = 1024,
  parameter int unsigned NUM_BITS = 32,
  localparam int unsigned ADDR_W  = $clog2(POS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // ROM side
  output logic [ADDR_W-1:0]   rom_addr_o,
  input  logic [NUM_BITS-1:0] rom_dout_i,
  // fetch port
  input  logic                f_req_i,
  input  logic [31:0]         f_pc_i,
  output logic                f_gnt_o,
  output logic                f_valid_o,
  output logic [NUM_BITS-1:0] f_data_o,
  output logic                f_err_o,
  input  logic                f_stall_i,
  // debug port
  input  logic                d_req_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  output logic                d_gnt_o,
  output logic                d_valid_o,
  output logic [NUM_BITS-1:0] d_data_o
);

  // Last granted port; reset to debug so fetch wins the first tie.
  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  port_e               rr_last_q, rr_last_d;
  logic                f_valid_q, f_valid_d;
  logic                f_err_q,   f_err_d;
  logic [NUM_BITS-1:0] f_data_q,  f_data_d;
  logic                d_valid_q, d_valid_d;
  logic [NUM_BITS-1:0] d_data_q,  d_data_d;

  logic                f_elig_c;
  logic                f_mis_c;
  logic                unused_pc_hi;

  // A fetch already holding a valid response under stall must not be re-served.
  assign f_elig_c = f_req_i && !(f_valid_q && f_stall_i);
  assign f_mis_c  = (f_pc_i[1:0] != 2'b00);

  // PC bits above the ROM word index are intentionally ignored (address wrap).
  assign unused_pc_hi = ^f_pc_i[31:ADDR_W+2];

  // Arbitration: grant selection, ROM address mux, round-robin next state.
  always_comb begin
    f_gnt_o    = 1'b0;
    d_gnt_o    = 1'b0;
    rom_addr_o = '0;
    rr_last_d  = rr_last_q;
    if (f_elig_c && (!d_req_i || (rr_last_q == PORT_D))) begin
      f_gnt_o    = 1'b1;
      rom_addr_o = f_pc_i[ADDR_W+1:2];
      rr_last_d  = PORT_F;
    end else if (d_req_i) begin
      d_gnt_o    = 1'b1;
      rom_addr_o = d_addr_i;
      rr_last_d  = PORT_D;
    end
  end

  // Response registers next state: capture on grant, hold fetch under stall.
  always_comb begin
    f_valid_d = f_valid_q;
    f_err_d   = f_err_q;
    f_data_d  = f_data_q;
    d_valid_d = 1'b0;
    d_data_d  = d_data_q;
    if (f_gnt_o) begin
      f_valid_d = 1'b1;
      f_err_d   = f_mis_c;
      f_data_d  = f_mis_c ? '0 : rom_dout_i;
    end else if (!f_stall_i) begin
      f_valid_d = 1'b0;
      f_err_d   = 1'b0;
    end
    if (d_gnt_o) begin
      d_valid_d = 1'b1;
      d_data_d  = rom_dout_i;
    end
  end

  // State and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_q <= PORT_D;
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
      f_data_q  <= '0;
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      f_valid_q <= f_valid_d;
      f_err_q   <= f_err_d;
      f_data_q  <= f_data_d;
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
    end
  end

  assign f_valid_o = f_valid_q;
  assign f_err_o   = f_err_q;
  assign f_data_o  = f_data_q;
  assign d_valid_o = d_valid_q;
  assign d_data_o  = d_data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: scenario tasks with inline checks plus a scoreboard
// that predicts every granted read's response from a local ROM model.
module tb_rom_arbiter;

  localparam int unsigned POS    = 1024;
  localparam int unsigned NB     = 32;
  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [NB-1:0]     rom_dout;
  logic              f_req, f_gnt, f_valid, f_err, f_stall;
  logic [31:0]       f_pc;
  logic [NB-1:0]     f_data;
  logic              d_req, d_gnt, d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [NB-1:0]     d_data;

  logic [NB-1:0] mem [POS];
  assign rom_dout = mem[rom_addr];

  int vectors;
  int miscompares;

  typedef struct {
    logic          err;
    logic [NB-1:0] data;
  } fexp_t;

  fexp_t         fq[$];
  logic [NB-1:0] dq[$];
  fexp_t         fe;
  logic [NB-1:0] de;
  logic          f_pend, d_pend, mon_en;

  rom_arbiter #(.POS(POS), .NUM_BITS(NB)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rom_addr_o (rom_addr),
    .rom_dout_i (rom_dout),
    .f_req_i    (f_req),
    .f_pc_i     (f_pc),
    .f_gnt_o    (f_gnt),
    .f_valid_o  (f_valid),
    .f_data_o   (f_data),
    .f_err_o    (f_err),
    .f_stall_i  (f_stall),
    .d_req_i    (d_req),
    .d_addr_i   (d_addr),
    .d_gnt_o    (d_gnt),
    .d_valid_o  (d_valid),
    .d_data_o   (d_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset drops every in-flight read.
  always @(negedge rst_n) begin
    fq.delete();
    dq.delete();
    f_pend = 1'b0;
    d_pend = 1'b0;
  end

  // Scoreboard: a grant seen at one falling edge must show up as a response at the next.
  always @(negedge clk) begin
    if (mon_en && rst_n === 1'b1) begin
      if (f_pend) begin
        fe = fq.pop_front();
        vectors++;
        if (f_valid !== 1'b1 || f_err !== fe.err || f_data !== fe.data) begin
          miscompares++;
          $display("FAIL sb_fetch: valid=%b err=%b data=%h, required valid=1 err=%b data=%h",
                   f_valid, f_err, f_data, fe.err, fe.data);
        end
      end
      vectors++;
      if (d_pend) begin
        de = dq.pop_front();
        if (d_valid !== 1'b1 || d_data !== de) begin
          miscompares++;
          $display("FAIL sb_debug: valid=%b data=%h, required valid=1 data=%h", d_valid, d_data, de);
        end
      end else if (d_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL sb_debug_idle: valid=%b, required 0", d_valid);
      end
      f_pend = (f_gnt === 1'b1);
      if (f_pend) begin
        fe.err  = (f_pc[1:0] != 2'b00);
        fe.data = fe.err ? '0 : mem[f_pc[11:2]];
        fq.push_back(fe);
      end
      d_pend = (d_gnt === 1'b1);
      if (d_pend) dq.push_back(mem[d_addr]);
    end
  end

  task automatic test_reset;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({f_valid, f_err, f_data, d_valid, d_data, f_gnt, d_gnt, rom_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: fv=%b fe=%b fd=%h dv=%b dd=%h fg=%b dg=%b addr=%h, required all 0",
               f_valid, f_err, f_data, d_valid, d_data, f_gnt, d_gnt, rom_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    f_req = 1'b1;
    f_pc = 32'h0;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || rom_addr !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_first_grant: fg=%b dg=%b addr=%h, required 1 0 000", f_gnt, d_gnt, rom_addr);
    end
    @(posedge clk);
    #1 f_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (f_valid !== 1'b1 || f_data !== 32'h0ff00013 || f_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_data: fv=%b fd=%h fe=%b, required 1 0ff00013 0", f_valid, f_data, f_err);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (f_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_drop: fv=%b, required 0", f_valid);
    end
  endtask

  task automatic test_sequential;
    logic [NB-1:0] seq_exp [3];
    seq_exp = '{32'h0ff08093, 32'h0ff10113, 32'h0ff18193};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 f_req = 1'b1;
      f_pc = 32'(4 * (i + 1));
      @(negedge clk);
      vectors++;
      if (f_gnt !== 1'b1 || rom_addr !== 10'(i + 1)) begin
        miscompares++;
        $display("FAIL seq_grant%0d: fg=%b addr=%h, required 1 %h", i, f_gnt, rom_addr, 10'(i + 1));
      end
      if (i > 0) begin
        vectors++;
        if (f_valid !== 1'b1 || f_data !== seq_exp[i-1]) begin
          miscompares++;
          $display("FAIL seq_data%0d: fv=%b fd=%h, required 1 %h", i - 1, f_valid, f_data, seq_exp[i-1]);
        end
      end
    end
    @(posedge clk);
    #1 f_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (f_valid !== 1'b1 || f_data !== seq_exp[2]) begin
      miscompares++;
      $display("FAIL seq_data2: fv=%b fd=%h, required 1 %h", f_valid, f_data, seq_exp[2]);
    end
  endtask

  task automatic test_contention;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    f_req = 1'b1;
    f_pc = 32'h0;
    d_req = 1'b1;
    d_addr = 10'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (f_gnt !== ((i % 2) == 0) || d_gnt !== ((i % 2) == 1)) begin
        miscompares++;
        $display("FAIL contend_grant%0d: fg=%b dg=%b, required %b %b", i, f_gnt, d_gnt,
                 (i % 2) == 0, (i % 2) == 1);
      end
      if (i > 0) begin
        vectors++;
        if ((i % 2) == 1 && (f_valid !== 1'b1 || f_data !== 32'h0ff00013)) begin
          miscompares++;
          $display("FAIL contend_fdata%0d: fv=%b fd=%h, required 1 0ff00013", i, f_valid, f_data);
        end
        if ((i % 2) == 0 && (d_valid !== 1'b1 || d_data !== 32'h0ff18193)) begin
          miscompares++;
          $display("FAIL contend_ddata%0d: dv=%b dd=%h, required 1 0ff18193", i, d_valid, d_data);
        end
      end
      @(posedge clk);
      #1;
    end
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_stall;
    @(posedge clk);
    #1 f_req = 1'b1;
    f_pc = 32'h4;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_setup_grant: fg=%b, required 1", f_gnt);
    end
    @(posedge clk);
    #1 f_pc = 32'h8;
    f_stall = 1'b1;
    d_req = 1'b1;
    d_addr = 10'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (f_gnt !== 1'b0 || d_gnt !== 1'b1 || f_valid !== 1'b1 ||
          f_data !== 32'h0ff08093 || f_err !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: fg=%b dg=%b fv=%b fd=%h fe=%b, required 0 1 1 0ff08093 0",
                 i, f_gnt, d_gnt, f_valid, f_data, f_err);
      end
      if (i > 0) begin
        vectors++;
        if (d_valid !== 1'b1 || d_data !== 32'h0ff10113) begin
          miscompares++;
          $display("FAIL stall_ddata%0d: dv=%b dd=%h, required 1 0ff10113", i, d_valid, d_data);
        end
      end
      @(posedge clk);
      #1;
    end
    f_stall = 1'b0;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || rom_addr !== 10'd2) begin
      miscompares++;
      $display("FAIL stall_release: fg=%b dg=%b addr=%h, required 1 0 002", f_gnt, d_gnt, rom_addr);
    end
    @(posedge clk);
    #1 f_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (d_gnt !== 1'b1 || f_valid !== 1'b1 || f_data !== 32'h0ff10113) begin
      miscompares++;
      $display("FAIL stall_after: dg=%b fv=%b fd=%h, required 1 1 0ff10113", d_gnt, f_valid, f_data);
    end
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  task automatic test_misaligned_wrap;
    @(posedge clk);
    #1 f_req = 1'b1;
    f_pc = 32'h6;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1 || rom_addr !== 10'd1) begin
      miscompares++;
      $display("FAIL mis_grant: fg=%b addr=%h, required 1 001", f_gnt, rom_addr);
    end
    @(posedge clk);
    #1 f_pc = 32'h1004;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1 || rom_addr !== 10'd1 || f_valid !== 1'b1 || f_err !== 1'b1 || f_data !== '0) begin
      miscompares++;
      $display("FAIL mis_resp: fg=%b addr=%h fv=%b fe=%b fd=%h, required 1 001 1 1 0",
               f_gnt, rom_addr, f_valid, f_err, f_data);
    end
    @(posedge clk);
    #1 f_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (f_valid !== 1'b1 || f_err !== 1'b0 || f_data !== 32'h0ff08093) begin
      miscompares++;
      $display("FAIL wrap_resp: fv=%b fe=%b fd=%h, required 1 0 0ff08093", f_valid, f_err, f_data);
    end
  endtask

  task automatic test_reset_midop;
    @(posedge clk);
    #1 f_req = 1'b1;
    f_pc = 32'h8;
    #1;
    vectors++;
    if (f_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_pre_grant: fg=%b, required 1", f_gnt);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 f_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (f_valid !== 1'b0 || f_gnt !== 1'b0) begin
        miscompares++;
        $display("FAIL midop_dropped%0d: fv=%b fg=%b, required 0 0", i, f_valid, f_gnt);
      end
      @(posedge clk);
      #1;
    end
    f_req = 1'b1;
    f_pc = 32'hC;
    d_req = 1'b1;
    d_addr = 10'd0;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_tie: fg=%b dg=%b, required 1 0", f_gnt, d_gnt);
    end
    @(posedge clk);
    #1 f_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (d_gnt !== 1'b1 || f_valid !== 1'b1 || f_data !== 32'h0ff18193) begin
      miscompares++;
      $display("FAIL midop_after: dg=%b fv=%b fd=%h, required 1 1 0ff18193", d_gnt, f_valid, f_data);
    end
    @(posedge clk);
    #1 d_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (d_valid !== 1'b1 || d_data !== 32'h0ff00013) begin
      miscompares++;
      $display("FAIL midop_ddata: dv=%b dd=%h, required 1 0ff00013", d_valid, d_data);
    end
  endtask

  task automatic test_back_to_back;
    logic fg, dg;
    int   fw, dw;
    fg = 1'b1;
    dg = 1'b1;
    fw = 0;
    dw = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (fg) begin
        f_req = ($urandom % 4) != 0;
        f_pc = $urandom;
      end
      if (dg) begin
        d_req = ($urandom % 4) != 0;
        d_addr = 10'($urandom);
      end
      @(negedge clk);
      fw = (f_req && f_gnt !== 1'b1) ? fw + 1 : 0;
      dw = (d_req && d_gnt !== 1'b1) ? dw + 1 : 0;
      vectors++;
      if ((f_gnt === 1'b1 && d_gnt === 1'b1) || fw > 1 || dw > 1 ||
          ((f_req || d_req) && f_gnt !== 1'b1 && d_gnt !== 1'b1)) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: fg=%b dg=%b fwait=%0d dwait=%0d, required one grant, waits<=1",
                 c, f_gnt, d_gnt, fw, dw);
      end
      fg = !f_req || (f_gnt === 1'b1);
      dg = !d_req || (d_gnt === 1'b1);
    end
    @(posedge clk);
    #1 f_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mon_en = 1'b0;
    f_pend = 1'b0;
    d_pend = 1'b0;
    f_req = 1'b0;
    f_pc = '0;
    f_stall = 1'b0;
    d_req = 1'b0;
    d_addr = '0;
    for (int i = 0; i < int'(POS); i++) mem[i] = 32'(i) * 32'h9e3779b1 ^ 32'h5a5a0000;
    mem[0] = 32'h0ff00013;
    mem[1] = 32'h0ff08093;
    mem[2] = 32'h0ff10113;
    mem[3] = 32'h0ff18193;

    test_reset();
    test_sequential();
    test_contention();
    test_stall();
    test_misaligned_wrap();
    test_reset_midop();
    test_back_to_back();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single combinational instruction ROM (word-addressed, POS words × NUM_BITS) between the core's fetch unit and a debug/loader read port. It applies round-robin arbitration and drives the ROM address from the winning request. It returns registered read data one cycle later. On the fetch side it converts the byte PC to a word index, flags misaligned fetches, and holds its response while the core stalls.

## Interface
- POS, 1024, number of ROM words; power of two; ADDR_W = $clog2(POS)
- NUM_BITS, 32, ROM word width
- CLK  in  1  system clock; all state updates on rising edge
- RST_n  in  1  asynchronous, active-low reset
- rom_addr  out  ADDR_W  word address to ROM `addr`; combinational from the granted request
- rom_dout  in  NUM_BITS  ROM `dout`; combinational, valid in the same cycle as rom_addr
- f_req  in  1  fetch request; held with f_pc stable until f_gnt
- f_pc  in  32  fetch byte address
- f_gnt  out  1  combinational; fetch request accepted at the coming edge
- f_valid  out  1  registered; f_data/f_err valid
- f_data  out  NUM_BITS  fetched instruction
- f_err  out  1  misaligned fetch (f_pc[1:0] != 0); f_data forced 0
- f_stall  in  1  core stall; holds f_valid/f_data/f_err unchanged
- d_req  in  1  debug request; held with d_addr stable until d_gnt
- d_addr  in  ADDR_W  debug word address
- d_gnt  out  1  combinational; debug request accepted at the coming edge
- d_valid  out  1  registered one-cycle pulse; d_data valid
- d_data  out  NUM_BITS  debug read data

## Operation
- Fetch eligible: f_req && !(f_valid && f_stall). Debug eligible: d_req.
- Only one eligible port: that port is granted. Both eligible: grant the port not granted last.
- rr_last records the last granted port and updates only on a grant. Reset value = debug, so fetch wins the first tie.
- Neither eligible: no grant and rom_addr = 0.
- Fetch grant: rom_addr = f_pc[ADDR_W+1:2]. Upper PC bits above ADDR_W+1 are ignored, so addresses wrap modulo POS words.
- Debug grant: rom_addr = d_addr.
- At most one of f_gnt and d_gnt is high in any cycle.
- Fetch response register, updated each edge:
  - f_gnt: f_valid←1; f_data←rom_dout, or 0 when misaligned; f_err←misaligned.
  - No grant, f_stall=1: hold f_valid, f_data, f_err.
  - No grant, f_stall=0: f_valid←0, f_err←0; f_data holds.
- Debug response register, updated each edge:
  - d_gnt: d_valid←1, d_data←rom_dout.
  - Otherwise: d_valid←0; d_data holds.
- Misaligned fetch still consumes an arbitration slot and still updates rr_last.
- Reset, including mid-transaction: f_valid, f_err, d_valid, f_data and d_data clear to 0 and rr_last = debug. In-flight grants are dropped, and requesters must re-request.

## Timing
- Grant is combinational in cycle N. Data is captured at the end of cycle N and valid in cycle N+1, so latency is 1 cycle.
- Throughput: one read per cycle total. A lone requester holding req gets back-to-back grants.
- Under contention each port waits at most 1 cycle. Alternation F,D,F,D holds while both stay eligible.
- A fetch stalled with f_valid=1 is not granted. Debug may use the ROM during the stall.
- When f_stall deasserts, fetch is eligible again in that same cycle.
- The requester may change addr/req in the cycle after its gnt. Changing them in a cycle with req=1 and gnt=0 is illegal.

## Test plan
ROM preloaded with mem[0..3] = 0x0ff00013, 0x0ff08093, 0x0ff10113, 0x0ff18193.
- Reset check: assert RST_n=0 mid-cycle -> all outputs 0 immediately. Release reset, f_req=1, f_pc=0x0 -> f_gnt=1, rom_addr=0; next cycle f_valid=1, f_data=0x0ff00013, f_err=0.
- Sequential fetch: f_pc=0x4, 0x8, 0xC on consecutive grants -> f_data 0x0ff08093, 0x0ff10113, 0x0ff18193 on 3 consecutive valid cycles.
- Contention: f_req and d_req both held 4 cycles, f_pc=0x0, d_addr=3 after reset -> grants F,D,F,D. f_data=0x0ff00013 and d_data=0x0ff18193 on alternating valid cycles.
- Stall: f_valid=1 with f_data=0x0ff08093 and f_stall=1 for 3 cycles, d_req=1, d_addr=2 -> f outputs unchanged; d_gnt each cycle and d_data=0x0ff10113. Release stall -> f_gnt the same cycle.
- Misaligned and wrap: f_pc=0x6 -> f_valid=1, f_err=1, f_data=0. f_pc=0x1004 (POS=1024) -> rom_addr=1, f_data=0x0ff08093.
- Reset mid-operation: RST_n pulled low while f_gnt=1 -> no f_valid after release until a new request is granted; the first tie after release goes to fetch.
